// File: rtl/source_ram_loader.sv
// Write stage for the 3-bank source RAM: packet stream -> per-bank aligned writes.
// Define SOURCE_RAM_LOADER_XOR_EN to enable the load_xor written-data accumulator.
module source_ram_loader #(
    parameter int WORDS_PER_PKT = 128,
    parameter int PKTS_PER_BANK = 4,
    parameter int NUM_BANKS     = 3
) (
    input  logic                                                     ram_clk,
    input  logic                                                     rst_n,
    input  logic                                                     load_start,
    input  logic                                                     in_valid,
    output logic                                                     in_ready,
    input  logic [127:0]                                             in_data,
    input  logic                                                     in_last,
    output logic [NUM_BANKS*128-1:0]                                 ram_data,
    output logic [NUM_BANKS-1:0]                                     ram_wren,
    output logic [NUM_BANKS*$clog2(WORDS_PER_PKT*PKTS_PER_BANK)-1:0] ram_address,
    output logic                                                     load_busy,
    output logic                                                     load_done,
    output logic [$clog2(NUM_BANKS*PKTS_PER_BANK+1)-1:0]             pkt_count,
    output logic                                                     len_err,
    output logic [127:0]                                             load_xor
);
    localparam int WORD_W   = $clog2(WORDS_PER_PKT);
    localparam int SLOT_W   = $clog2(PKTS_PER_BANK);
    localparam int ADDR_W   = WORD_W + SLOT_W;
    localparam int NUM_PKTS = NUM_BANKS * PKTS_PER_BANK;
    localparam int PKT_W    = $clog2(NUM_PKTS + 1);
    // One extra bit so the word counter can sit at WORDS_PER_PKT and flag overlong packets.
    localparam int CNT_W    = WORD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            word_q, word_d;
    logic [PKT_W-1:0]            pkt_q, pkt_d;
    logic                        len_err_q, len_err_d;
    logic [NUM_BANKS-1:0]        wren_q, wren_d;
    logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_BANKS*128-1:0]    data_q, data_d;
    logic                        accept;
    logic [PKT_W-1:0]            bank;
    logic [ADDR_W-1:0]           slot_addr;

    assign in_ready  = (state_q == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign bank      = pkt_q >> SLOT_W;
    assign slot_addr = {pkt_q[SLOT_W-1:0], word_q[WORD_W-1:0]};

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        pkt_d     = pkt_q;
        len_err_d = len_err_q;
        wren_d    = '0;
        addr_d    = '0;
        data_d    = data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d   = S_LOAD;
                    word_d    = '0;
                    pkt_d     = '0;
                    len_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (word_q < CNT_W'(WORDS_PER_PKT)) begin
                        for (int k = 0; k < NUM_BANKS; k++) begin
                            if (bank == PKT_W'(k)) begin
                                wren_d[k] = 1'b1;
                                addr_d[k*ADDR_W +: ADDR_W] = slot_addr;
                            end
                        end
                        data_d = {NUM_BANKS{in_data}};
                        word_d = word_q + 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                    end
                    // Short packets still advance to the next aligned slot.
                    if (in_last) begin
                        if (word_q != CNT_W'(WORDS_PER_PKT - 1)) begin
                            len_err_d = 1'b1;
                        end
                        word_d = '0;
                        pkt_d  = pkt_q + 1'b1;
                        if (pkt_q == PKT_W'(NUM_PKTS - 1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            pkt_q     <= '0;
            len_err_q <= 1'b0;
            wren_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            pkt_q     <= pkt_d;
            len_err_q <= len_err_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

`ifdef SOURCE_RAM_LOADER_XOR_EN
    logic [127:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if ((state_q != S_LOAD) && load_start) begin
            xor_d = '0;
        end else if (|wren_d) begin
            xor_d = xor_q ^ in_data;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end

    assign load_xor = xor_q;
`else
    assign load_xor = '0;
`endif

    assign ram_wren    = wren_q;
    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign load_busy   = (state_q == S_LOAD);
    assign load_done   = (state_q == S_DONE);
    assign pkt_count   = pkt_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_source_ram_loader.sv
// Directed bench for source_ram_loader: nominal, bubbles, short/long packets, reset, restart.
module tb_source_ram_loader;
    logic         ram_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic [383:0] ram_data;
    logic [2:0]   ram_wren;
    logic [26:0]  ram_address;
    logic         load_busy;
    logic         load_done;
    logic [3:0]   pkt_count;
    logic         len_err;
    logic [127:0] load_xor;

    int           n_cmp = 0;
    int           n_fail = 0;
    int           bad = 0;
    logic [127:0] exp_xor = '0;
    logic [2:0]   first_wren;
    logic [26:0]  first_addr;
    logic [2:0]   cap_wren[1536];
    logic [26:0]  cap_addr[1536];

    typedef struct {
        int          beat;
        logic [2:0]  wren;
        logic [26:0] addr;
    } probe_t;
    probe_t probes[9];

    source_ram_loader dut (
        .ram_clk    (ram_clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_address(ram_address),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .pkt_count  (pkt_count),
        .len_err    (len_err),
        .load_xor   (load_xor)
    );

    always #5 ram_clk = ~ram_clk;

    task automatic step();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] xor_expect(input logic [127:0] acc);
`ifdef SOURCE_RAM_LOADER_XOR_EN
        return acc;
`else
        return acc & 128'h0;
`endif
    endfunction

    // Checks the registered outputs for beat w of packet p (called after its accepting edge).
    task automatic expect_write(input int p, input int w, input logic [127:0] d);
        logic [2:0]  ew;
        logic [26:0] ea;
        if (w < 128) begin
            ew = 3'(1 << (p / 4));
            ea = 27'((p % 4) * 128 + w) << (9 * (p / 4));
            exp_xor ^= d;
            if (ram_wren !== ew || ram_address !== ea || ram_data !== {3{d}}) bad++;
        end else if (ram_wren !== 3'b000) begin
            bad++;
        end
    endtask

    task automatic send_pkt(input int p, input int n, input bit with_last);
        for (int w = 0; w < n; w++) begin
            logic [127:0] d;
            d = {32'hC0DE0000 + 32'(p), 64'h0123456789ABCDEF, 32'(w)};
            in_valid = 1'b1;
            in_data  = d;
            in_last  = with_last && (w == n - 1);
            step();
            if (w == 0) begin
                first_wren = ram_wren;
                first_addr = ram_address;
            end
            expect_write(p, w, d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic exp_len_err);
        check({tag, "_load_done"}, load_done, 1'b1);
        check({tag, "_pkt_count"}, pkt_count, 4'd12);
        check({tag, "_len_err"}, len_err, exp_len_err);
        check({tag, "_load_xor"}, load_xor, xor_expect(exp_xor));
        check({tag, "_writes"}, bad, 0);
        bad = 0;
    endtask

    task automatic full_load(input bit bubbles, input bit start_mid, input bit start_last, input string tag);
        int b;
        int cyc;
        bit v;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_xor = '0;
        check({tag, "_busy"}, load_busy, 1'b1);
        b = 0;
        cyc = 0;
        while (b < 1536 && cyc < 8000) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid   = v;
            in_data    = 128'(b);
            in_last    = (b % 128 == 127);
            load_start = (start_mid && b == 700) || (start_last && b == 1535);
            step();
            cyc++;
            load_start = 1'b0;
            if (v) begin
                cap_wren[b] = ram_wren;
                cap_addr[b] = ram_address;
                expect_write(b / 128, b % 128, 128'(b));
                b++;
            end else if (ram_wren !== 3'b000) begin
                bad++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_beats"}, b, 1536);
        check_done(tag, 1'b0);
        step();
        check({tag, "_done_hold"}, load_done, 1'b1);
        check({tag, "_no_write_after"}, ram_wren, 3'b000);
    endtask

    initial begin
        probes[0] = '{0,    3'b001, 27'd0};
        probes[1] = '{127,  3'b001, 27'd127};
        probes[2] = '{128,  3'b001, 27'd128};
        probes[3] = '{511,  3'b001, 27'd511};
        probes[4] = '{512,  3'b010, 27'd0};
        probes[5] = '{513,  3'b010, 27'h200};
        probes[6] = '{1023, 3'b010, 27'h3FE00};
        probes[7] = '{1024, 3'b100, 27'd0};
        probes[8] = '{1535, 3'b100, 27'h7FC0000};

        // Reset state
        step();
        step();
        check("rst_wren", ram_wren, 3'b000);
        check("rst_addr", ram_address, 27'd0);
        check("rst_data", ram_data, 384'd0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_busy", load_busy, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_pkt_count", pkt_count, 4'd0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_xor", load_xor, 128'd0);
        rst_n = 1'b1;

        // in_valid while IDLE is not accepted
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        check("idle_ready", in_ready, 1'b0);
        check("idle_wren", ram_wren, 3'b000);
        check("idle_busy", load_busy, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Nominal load, with a stray load_start mid-load that must be ignored
        full_load(1'b0, 1'b1, 1'b0, "nominal");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("probe_wren_%0d", probes[i].beat), cap_wren[probes[i].beat], probes[i].wren);
            check($sformatf("probe_addr_%0d", probes[i].beat), cap_addr[probes[i].beat], probes[i].addr);
        end

        // Random bubbles, restarted from DONE
        full_load(1'b1, 1'b0, 1'b0, "bubbles");

        // Short packet 0 (100 beats)
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_xor = '0;
        send_pkt(0, 100, 1'b1);
        check("short_len_err", len_err, 1'b1);
        check("short_pkt_count", pkt_count, 4'd1);
        send_pkt(1, 128, 1'b1);
        check("short_p1_wren", first_wren, 3'b001);
        check("short_p1_addr", first_addr, 27'd128);
        for (int p = 2; p < 12; p++) send_pkt(p, 128, 1'b1);
        check_done("short", 1'b1);

        // Restart from DONE clears the per-load status
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_xor = '0;
        check("restart_pkt_count", pkt_count, 4'd0);
        check("restart_len_err", len_err, 1'b0);
        check("restart_xor", load_xor, 128'd0);
        check("restart_busy", load_busy, 1'b1);
        check("restart_done", load_done, 1'b0);

        // Long packet 5 (130 beats): the last two beats are dropped
        for (int p = 0; p < 5; p++) send_pkt(p, 128, 1'b1);
        check("long_pre_len_err", len_err, 1'b0);
        send_pkt(5, 130, 1'b1);
        check("long_len_err", len_err, 1'b1);
        send_pkt(6, 128, 1'b1);
        check("long_p6_wren", first_wren, 3'b010);
        check("long_p6_addr", first_addr, 27'h20000);
        for (int p = 7; p < 12; p++) send_pkt(p, 128, 1'b1);
        check_done("long", 1'b1);

        // Reset after 300 beats of a new load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        send_pkt(0, 128, 1'b1);
        send_pkt(1, 128, 1'b1);
        send_pkt(2, 44, 1'b0);
        check("midrst_pre_writes", bad, 0);
        bad = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        step();
        check("midrst_wren", ram_wren, 3'b000);
        check("midrst_addr", ram_address, 27'd0);
        check("midrst_data", ram_data, 384'd0);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_busy", load_busy, 1'b0);
        check("midrst_done", load_done, 1'b0);
        check("midrst_pkt_count", pkt_count, 4'd0);
        check("midrst_len_err", len_err, 1'b0);
        check("midrst_xor", load_xor, 128'd0);
        rst_n = 1'b1;
        step();
        check("midrst_idle_wren", ram_wren, 3'b000);
        check("midrst_idle_ready", in_ready, 1'b0);
        in_valid = 1'b0;

        // Fresh load after reset, with load_start coinciding with the final in_last
        full_load(1'b0, 1'b0, 1'b1, "after_rst");
        check("after_rst_beat0_wren", cap_wren[0], 3'b001);
        check("after_rst_beat0_addr", cap_addr[0], 27'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
